// File: rtl/rv32i_pkg.sv
// Shared RV32I decode encodings and LSU types; loadtype/storetype values mirror the control unit.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package rv32i_pkg;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b011,
    LD_LHU = 3'b100
  } loadtype_e;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } storetype_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC1 = 2'b01,
    ACC2 = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // Unlisted encodings (LT 101-111, ST 11) fall through to word size.
  function automatic size_e op_size(input logic store, input logic [2:0] lt, input logic [1:0] st);
    if (store) begin
      case (st)
        ST_SB:   return SZ_B;
        ST_SH:   return SZ_H;
        default: return SZ_W;
      endcase
    end
    case (lt)
      LD_LB, LD_LBU: return SZ_B;
      LD_LH, LD_LHU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] k);
    return (sz == SZ_H && k[0]) || (sz == SZ_W && k != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: byte-enable mask over two words, rotated store data, shifted/extended load data.
// Latency: combinational.
// Backpressure: none.
module lsu_align import rv32i_pkg::*; (
  input  logic [1:0]  k,
  input  size_e       size,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  be_mask,
  output logic [31:0] wdata_rot,
  output logic [31:0] ld_data
);

  logic [5:0]  sh;
  logic [3:0]  base;
  logic [31:0] rlo;

  always_comb begin
    sh = {k, 3'b000};
    case (size)
      SZ_B:    base = 4'b0001;
      SZ_H:    base = 4'b0011;
      default: base = BE_ALL;
    endcase
    be_mask = {4'b0000, base} << k;
    // A 32-bit right shift yields 0, so k=0 degenerates cleanly to wdata.
    wdata_rot = (wdata << sh) | (wdata >> (6'd32 - sh));
    rlo = 32'(rdata >> sh);
    case (size)
      SZ_B:    ld_data = {{24{sign & rlo[7]}}, rlo[7:0]};
      SZ_H:    ld_data = {{16{sign & rlo[15]}}, rlo[15:0]};
      default: ld_data = rlo;
    endcase
  end

endmodule

// File: rtl/lsu_rv32i.sv
// RV32I load/store unit: one request -> one or two word accesses on a req/ack port -> done pulse.
// Latency: 2 cycles min aligned, 3 split (LSU_MISALIGN_SPLIT_EN), 1 for a rejected misaligned access.
// Backpressure: busy high while in flight, requests dropped; mem_* held stable until mem_ack.
module lsu_rv32i import rv32i_pkg::*; #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [2:0]        req_loadtype,
  input  logic [1:0]        req_storetype,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rd_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  lsu_state_e        state, state_n;
  logic              store_q, sign_q, split_q;
  size_e             size_q;
  logic [1:0]        k_q;
  logic [31:0]       word0_q;

  size_e             size_in, a_size;
  logic              sign_in, mis_in, a_sign;
  logic [1:0]        a_k;
  logic [63:0]       a_rdata;
  logic [7:0]        be_mask;
  logic [31:0]       wdata_rot, ld_data;

  logic              done_n, err_n, mem_req_n, mem_we_n;
  logic [3:0]        mem_be_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [31:0]       mem_wdata_n, rd_data_n;

  // In IDLE the aligner sees the live request; afterwards the latched one.
  always_comb begin
    size_in = op_size(req_store, req_loadtype, req_storetype);
    sign_in = !req_store && (req_loadtype == LD_LB || req_loadtype == LD_LH);
    mis_in  = misaligned(size_in, req_addr[1:0]);
    a_k     = (state == IDLE) ? req_addr[1:0] : k_q;
    a_size  = (state == IDLE) ? size_in : size_q;
    a_sign  = (state == IDLE) ? sign_in : sign_q;
    a_rdata = (state == ACC2) ? {mem_rdata, word0_q} : {32'h0, mem_rdata};
  end

  lsu_align u_align (
    .k         (a_k),
    .size      (a_size),
    .sign      (a_sign),
    .wdata     (req_wdata),
    .rdata     (a_rdata),
    .be_mask   (be_mask),
    .wdata_rot (wdata_rot),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_n     = state;
    done_n      = 1'b0;
    err_n       = 1'b0;
    rd_data_n   = 32'h0;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_be_n    = mem_be;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (mis_in && !SPLIT_EN) begin
            state_n = RESP;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n     = ACC1;
            mem_req_n   = 1'b1;
            mem_we_n    = req_store;
            mem_be_n    = req_store ? be_mask[3:0] : 4'b0000;
            mem_addr_n  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_n = req_store ? wdata_rot : 32'h0;
          end
        end
      end
      ACC1, ACC2: begin
        if (mem_ack) begin
          if (state == ACC1 && split_q) begin
            // mem_req stays high straight into the second word.
            state_n    = ACC2;
            mem_be_n   = store_q ? be_mask[7:4] : 4'b0000;
            mem_addr_n = mem_addr + ADDR_W'(4);
          end else begin
            state_n   = RESP;
            done_n    = 1'b1;
            rd_data_n = store_q ? 32'h0 : ld_data;
            mem_req_n = 1'b0;
            mem_we_n  = 1'b0;
            mem_be_n  = 4'b0000;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_data   <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      store_q   <= 1'b0;
      sign_q    <= 1'b0;
      split_q   <= 1'b0;
      size_q    <= SZ_B;
      k_q       <= 2'b00;
      word0_q   <= 32'h0;
    end else begin
      state     <= state_n;
      busy      <= (state_n != IDLE);
      done      <= done_n;
      err       <= err_n;
      rd_data   <= rd_data_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_be    <= mem_be_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      if (state == IDLE && req_valid) begin
        store_q <= req_store;
        sign_q  <= sign_in;
        split_q <= SPLIT_EN && mis_in;
        size_q  <= size_in;
        k_q     <= req_addr[1:0];
      end
      if (state == ACC1 && mem_ack) word0_q <= mem_rdata;
    end
  end

endmodule
